// File: rtl/renkon_pool_if.sv
// Stream and control bundle between the renkon core array and the pooling stage.
// master drives configuration and pixels; slave returns pooled pixels and status.
interface renkon_pool_if #(
  parameter int DWIDTH = 16,
  parameter int LWIDTH = 10
);
  logic                     req;
  logic [LWIDTH-1:0]        map_size;
  logic [LWIDTH-1:0]        pool_size;
  logic                     in_valid;
  logic signed [DWIDTH-1:0] in_data;
  logic                     out_valid;
  logic signed [DWIDTH-1:0] out_data;
  logic                     busy;
  logic                     ack;

  modport master (
    output req, map_size, pool_size, in_valid, in_data,
    input  out_valid, out_data, busy, ack
  );

  modport slave (
    input  req, map_size, pool_size, in_valid, in_data,
    output out_valid, out_data, busy, ack
  );
endinterface

// File: rtl/renkon_pool.sv
// ReLU + non-overlapping max pooling over a row-major conv-map stream.
// Column partial maxima live in a line buffer so every pixel is read once.
//
//   state  | meaning
//   S_IDLE | waiting for req; latches map_size / pool_size
//   S_RUN  | consuming pixels, emitting one pooled pixel per closed window
//   S_DONE | last pixel consumed; ack for one cycle
module renkon_pool #(
  parameter int DWIDTH = 16,
  parameter int LWIDTH = 10,
  parameter int MAXW   = 64,
  parameter int MAXP   = 4
) (
  input  logic            clk,
  input  logic            xrst,
  renkon_pool_if.slave    bus
);

  localparam int OW = $clog2(MAXW);
  localparam int PW = $clog2(MAXP) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [LWIDTH-1:0]        psz;
  logic [LWIDTH-1:0]        msz;
  logic [LWIDTH-1:0]        col_rem;
  logic [LWIDTH-1:0]        row_rem;
  logic [PW-1:0]            psz_m1;
  logic [PW-1:0]            cph;
  logic [PW-1:0]            rph;
  logic [OW-1:0]            oc;
  logic                     col_ok_q;
  logic                     row_ok_q;
  logic signed [DWIDTH-1:0] rmax;
  logic signed [DWIDTH-1:0] line_buf [MAXW];

  logic                     accept;
  logic                     col_last;
  logic                     row_last;
  logic                     cph_last;
  logic                     rph_last;
  logic                     col_ok;
  logic                     row_ok;
  logic                     win_ok;
  logic signed [DWIDTH-1:0] din;
  logic signed [DWIDTH-1:0] m;
  logic signed [DWIDTH-1:0] bval;
  logic signed [DWIDTH-1:0] wval;
  logic signed [DWIDTH-1:0] relu;

  assign din      = bus.in_data;
  assign accept   = (state_q == S_RUN) && bus.in_valid;
  assign col_last = (col_rem == LWIDTH'(1));
  assign row_last = (row_rem == LWIDTH'(1));
  assign cph_last = (cph == psz_m1);
  assign rph_last = (rph == psz_m1);

  // A window is kept only if enough columns/rows remain at its first pixel.
  assign col_ok = (cph == '0) ? (col_rem >= psz) : col_ok_q;
  assign row_ok = (rph == '0) ? (row_rem >= psz) : row_ok_q;
  assign win_ok = accept && cph_last && col_ok && row_ok;

  assign m    = ((cph == '0) || (din > rmax)) ? din : rmax;
  assign bval = line_buf[oc];
  assign wval = ((rph == '0) || (m > bval)) ? m : bval;
  assign relu = wval[DWIDTH-1] ? '0 : wval;

  assign bus.busy = (state_q != S_IDLE);
  assign bus.ack  = (state_q == S_DONE);

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.req) state_d = S_RUN;
      S_RUN:  if (accept && col_last && row_last) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      msz           <= '0;
      psz           <= '0;
      psz_m1        <= '0;
      col_rem       <= '0;
      row_rem       <= '0;
      cph           <= '0;
      rph           <= '0;
      oc            <= '0;
      col_ok_q      <= 1'b0;
      row_ok_q      <= 1'b0;
      rmax          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      bus.out_valid <= win_ok && rph_last;
      if (win_ok && rph_last) bus.out_data <= relu;

      if (state_q == S_IDLE && bus.req) begin
        msz      <= bus.map_size;
        psz      <= bus.pool_size;
        psz_m1   <= PW'(bus.pool_size - LWIDTH'(1));
        col_rem  <= bus.map_size;
        row_rem  <= bus.map_size;
        cph      <= '0;
        rph      <= '0;
        oc       <= '0;
        col_ok_q <= 1'b0;
        row_ok_q <= 1'b0;
      end else if (accept) begin
        rmax     <= m;
        col_ok_q <= col_ok;
        row_ok_q <= row_ok;
        if (col_last) begin
          col_rem <= msz;
          cph     <= '0;
          oc      <= '0;
          row_rem <= row_rem - LWIDTH'(1);
          rph     <= rph_last ? '0 : rph + PW'(1);
        end else begin
          col_rem <= col_rem - LWIDTH'(1);
          cph     <= cph_last ? '0 : cph + PW'(1);
          if (cph_last) oc <= oc + OW'(1);
        end
      end
    end
  end

  // Buffer contents need no reset: each band overwrites them at rph==0.
  always_ff @(posedge clk) begin
    if (win_ok) line_buf[oc] <= wval;
  end

endmodule

// File: tb/tb_renkon_pool.sv
// Directed bench for renkon_pool: driver pushes expected pooled pixels and ack
// cycles into queues, a negedge monitor pops and compares them.
module tb_renkon_pool;

  logic clk = 1'b0;
  logic xrst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   ack_q[$];

  renkon_pool_if #(.DWIDTH(16), .LWIDTH(10)) bif ();

  renkon_pool #(.DWIDTH(16), .LWIDTH(10), .MAXW(64), .MAXP(4)) dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (bif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req_v);
    n_chk++;
    if (act != req_v) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!xrst) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        n_chk++; n_fail++;
        $display("FAIL missed_out: no out_valid at cycle %0d, required value %0d", e.cyc, e.val);
      end
      if (ack_q.size() > 0 && ack_q[0] < cyc) begin
        int a;
        a = ack_q.pop_front();
        n_chk++; n_fail++;
        $display("FAIL missed_ack: no ack at cycle %0d", a);
      end
      if (bif.out_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_out: out_valid with data %0d at cycle %0d, required none", bif.out_data, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", int'(bif.out_data), e.val);
          check("out_cycle", cyc, e.cyc);
        end
      end
      if (bif.ack) begin
        if (ack_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_ack: ack at cycle %0d, required none", cyc);
        end else begin
          check("ack_cycle", cyc, ack_q.pop_front());
        end
      end
    end
  end

  task automatic next_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_req(input int msz, input int psz);
    next_slot();
    check("busy_idle", int'(bif.busy), 0);
    bif.req = 1'b1;
    bif.map_size = 10'(msz);
    bif.pool_size = 10'(psz);
    bif.in_valid = 1'b0;
    next_slot();
    bif.req = 1'b0;
    check("busy_run", int'(bif.busy), 1);
  endtask

  // Feed one map; eidx lists the pixel indices that close a kept window.
  task automatic run_map(input int msz, input int psz, input int pix[$],
                         input int eidx[$], input int evals[$],
                         input bit gaps, input int req_at);
    int k;
    k = 0;
    issue_req(msz, psz);
    for (int i = 0; i < pix.size(); i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        bif.in_valid = 1'b0;
        next_slot();
      end
      bif.in_valid = 1'b1;
      bif.in_data = 16'(pix[i]);
      bif.req = (i == req_at);
      bif.map_size = (i == req_at) ? 10'd2 : 10'(msz);
      if (k < eidx.size() && eidx[k] == i) begin
        exp_q.push_back('{evals[k], cyc + 1});
        k++;
      end
      if (i == pix.size() - 1) ack_q.push_back(cyc + 1);
      next_slot();
    end
    bif.in_valid = 1'b0;
    bif.req = 1'b0;
    bif.map_size = 10'(msz);
    @(negedge clk);
    #1;
    check("out_drained", exp_q.size(), 0);
    check("ack_drained", ack_q.size(), 0);
  endtask

  int pix[$];
  int eidx[$];
  int evals[$];

  initial begin
    bif.req = 1'b0;
    bif.map_size = '0;
    bif.pool_size = '0;
    bif.in_valid = 1'b0;
    bif.in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(bif.out_valid), 0);
    check("rst_out_data", int'(bif.out_data), 0);
    check("rst_busy", int'(bif.busy), 0);
    check("rst_ack", int'(bif.ack), 0);
    xrst = 1'b0;

    // 4x4 / 2, values 1..16
    pix = {}; for (int i = 0; i < 16; i++) pix.push_back(i + 1);
    eidx = '{5, 7, 13, 15};
    evals = '{6, 8, 14, 16};
    run_map(4, 2, pix, eidx, evals, 1'b0, -1);

    // 5x5 / 2, values 0..24: last column and row dropped (back-to-back req)
    pix = {}; for (int i = 0; i < 25; i++) pix.push_back(i);
    eidx = '{6, 8, 16, 18};
    evals = '{6, 8, 16, 18};
    run_map(5, 2, pix, eidx, evals, 1'b0, -1);

    // 4x4 / 2, all negative except one window holding -32768 and +3
    pix = {}; for (int i = 0; i < 16; i++) pix.push_back(-(i + 1));
    pix[2] = -32768;
    pix[7] = 3;
    eidx = '{5, 7, 13, 15};
    evals = '{0, 3, 0, 0};
    run_map(4, 2, pix, eidx, evals, 1'b0, -1);

    // 3x3 / 1: every pixel passes through ReLU
    pix = '{-5, 7, 0, -32768, 32767, -1, 1, 100, -100};
    eidx = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
    evals = '{0, 7, 0, 0, 32767, 0, 1, 100, 0};
    run_map(3, 1, pix, eidx, evals, 1'b0, -1);

    // 8x8 / 4 with random gaps; spike of 100 inside window (0,1); req while busy
    pix = {}; for (int i = 0; i < 64; i++) pix.push_back(i);
    pix[13] = 100;
    eidx = '{27, 31, 59, 63};
    evals = '{27, 100, 59, 63};
    run_map(8, 4, pix, eidx, evals, 1'b1, 20);

    // Reset after 10 pixels of a 4x4 / 2 map
    issue_req(4, 2);
    for (int i = 0; i < 10; i++) begin
      bif.in_valid = 1'b1;
      bif.in_data = 16'(i + 1);
      if (i == 5) exp_q.push_back('{6, cyc + 1});
      if (i == 7) exp_q.push_back('{8, cyc + 1});
      next_slot();
    end
    bif.in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_drained", exp_q.size(), 0);
    xrst = 1'b1;
    #1;
    check("mid_rst_out_valid", int'(bif.out_valid), 0);
    check("mid_rst_out_data", int'(bif.out_data), 0);
    check("mid_rst_busy", int'(bif.busy), 0);
    check("mid_rst_ack", int'(bif.ack), 0);
    repeat (2) @(posedge clk);
    #1;
    xrst = 1'b0;
    repeat (6) next_slot();
    check("post_rst_busy", int'(bif.busy), 0);

    pix = {}; for (int i = 0; i < 16; i++) pix.push_back(i + 1);
    eidx = '{5, 7, 13, 15};
    evals = '{6, 8, 14, 16};
    run_map(4, 2, pix, eidx, evals, 1'b0, -1);

    repeat (3) next_slot();
    check("final_busy", int'(bif.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
